// File: rtl/wb_snoop_pkg.sv
// wb_snoop_pkg
// Shared encodings for the coherent snoop sequencer: the snoop type that is
// broadcast to the cores, the per-core snoop response codes, and the
// sequencer FSM states.
package wb_snoop_pkg;

  typedef enum logic [1:0] {
    SNOOP_TYPE_IDLE     = 2'b00,
    SNOOP_TYPE_READ     = 2'b01,
    SNOOP_TYPE_WRITE    = 2'b10,
    SNOOP_TYPE_NOT_USED = 2'b11
  } snoop_type_e;

  typedef enum logic [1:0] {
    SNOOP_RESP_PENDING = 2'b00,
    SNOOP_RESP_MISS    = 2'b01,
    SNOOP_RESP_HIT     = 2'b10,
    SNOOP_RESP_ACK     = 2'b11
  } snoop_resp_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_SNOOP   = 2'b01,
    ST_FORWARD = 2'b10,
    ST_MEM     = 2'b11
  } snoop_state_e;

endpackage

// File: rtl/wb_snoop_collect.sv
// wb_snoop_collect
// Collects snoop responses for one transaction: sticky per-core seen/hit
// masks, lowest-index hit selection and capture of the winning core's data.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start_i       clear the collector (new transaction accepted)
//   active_i      sequencer is in the snoop phase; responses are sampled
//   en_mask_i     cores whose responses count (requester excluded)
//   is_read_i     1 = read transaction (hits possible), 0 = write
//   resp_i        per-core 2-bit responses
//   dat_i         per-core snoop data
//   all_seen_o    every enabled core has responded, including this cycle
//   any_hit_o     at least one hit captured, including this cycle
//   hit_dat_o     data of the lowest-index hitting core, including this cycle
module wb_snoop_collect
  import wb_snoop_pkg::*;
#(
  parameter int dw        = 32,
  parameter int num_cores = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    active_i,
  input  logic [num_cores-1:0]    en_mask_i,
  input  logic                    is_read_i,
  input  logic [num_cores*2-1:0]  resp_i,
  input  logic [num_cores*dw-1:0] dat_i,
  output logic                    all_seen_o,
  output logic                    any_hit_o,
  output logic [dw-1:0]           hit_dat_o
);

  logic [num_cores-1:0] seen_q, seen_d;
  logic [num_cores-1:0] hit_q, hit_d;
  logic [dw-1:0]        hit_dat_q, hit_dat_d;
  logic [num_cores-1:0] new_seen;
  logic [num_cores-1:0] new_hit;
  logic                 found;

  // hit_dat_q always holds the data of the lowest-index core in hit_q, so a
  // new hit only replaces it when it becomes the lowest index overall.
  always_comb begin
    new_seen  = '0;
    new_hit   = '0;
    found     = 1'b0;
    hit_dat_d = hit_dat_q;
    for (int i = 0; i < num_cores; i++) begin
      if (active_i && en_mask_i[i] && !seen_q[i] &&
          resp_i[2*i +: 2] != SNOOP_RESP_PENDING) begin
        new_seen[i] = 1'b1;
        if (is_read_i && resp_i[2*i +: 2] == SNOOP_RESP_HIT) begin
          new_hit[i] = 1'b1;
        end
      end
    end
    seen_d = seen_q | new_seen;
    hit_d  = hit_q | new_hit;
    for (int i = 0; i < num_cores; i++) begin
      if (hit_d[i] && !found) begin
        found = 1'b1;
        if (new_hit[i]) begin
          hit_dat_d = dat_i[i*dw +: dw];
        end
      end
    end
    if (start_i) begin
      seen_d    = '0;
      hit_d     = '0;
      hit_dat_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_q    <= '0;
      hit_q     <= '0;
      hit_dat_q <= '0;
    end else begin
      seen_q    <= seen_d;
      hit_q     <= hit_d;
      hit_dat_q <= hit_dat_d;
    end
  end

  assign all_seen_o = &(seen_d | ~en_mask_i);
  assign any_hit_o  = |hit_d;
  assign hit_dat_o  = hit_dat_d;

endmodule

// File: rtl/wb_snoop_ctrl.sv
// wb_snoop_ctrl
// Sequences one coherent transaction: accept a granted request, broadcast a
// snoop to all other cores, collect responses, then either forward hit data
// or hand the transaction to the memory path and wait for completion.
// Optional feature: define WB_SNOOP_TIMEOUT_EN to bound the snoop phase to
// snoop_timeout cycles (timeout_o pulses and the transaction goes to memory).
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   req_valid_i/req_ready_o  request handshake (ready only in IDLE)
//   req_core_i/adr/we        requesting core, address, write flag
//   snoop_adr/type/en_o      snoop broadcast
//   snoop_response_i         per-core responses, snooped_dat_i per-core data
//   mem_req_o, mem_done_i    memory path release and completion
//   fwd_valid_o, fwd_dat_o   forwarded hit data
//   done_o, timeout_o        completion and snoop timeout pulses
module wb_snoop_ctrl
  import wb_snoop_pkg::*;
#(
  parameter int  dw            = 32,
  parameter int  aw            = 32,
  parameter int  num_cores     = 2,
  parameter int  snoop_timeout = 16,
  localparam int sel_bits      = (num_cores > 1) ? $clog2(num_cores) : 1
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic                    req_valid_i,
  output logic                    req_ready_o,
  input  logic [sel_bits-1:0]     req_core_i,
  input  logic [aw-1:0]           req_adr_i,
  input  logic                    req_we_i,
  output logic [aw-1:0]           snoop_adr_o,
  output logic [1:0]              snoop_type_o,
  output logic [num_cores-1:0]    snoop_en_o,
  input  logic [num_cores*2-1:0]  snoop_response_i,
  input  logic [num_cores*dw-1:0] snooped_dat_i,
  output logic                    mem_req_o,
  input  logic                    mem_done_i,
  output logic                    fwd_valid_o,
  output logic [dw-1:0]           fwd_dat_o,
  output logic                    done_o,
  output logic                    timeout_o
);

  snoop_state_e         state_q, state_d;
  logic [aw-1:0]        adr_q, adr_d;
  logic                 we_q, we_d;
  logic [sel_bits-1:0]  core_q, core_d;
  logic [dw-1:0]        fwd_dat_q, fwd_dat_d;
  logic [num_cores-1:0] en_mask;
  logic                 col_start;
  logic                 col_active;
  logic                 all_seen;
  logic                 any_hit;
  logic [dw-1:0]        hit_dat;

`ifdef WB_SNOOP_TIMEOUT_EN
  localparam int cnt_w = $clog2(snoop_timeout) + 1;
  logic [cnt_w-1:0] cnt_q, cnt_d;
  logic             timeout_hit;
  assign timeout_hit = (cnt_q == cnt_w'(snoop_timeout - 1));
`else
  assign timeout_o = 1'b0;
`endif

  // Every core except the requester is snooped.
  always_comb begin
    for (int i = 0; i < num_cores; i++) begin
      en_mask[i] = (core_q != sel_bits'(i));
    end
  end

  wb_snoop_collect #(
    .dw        (dw),
    .num_cores (num_cores)
  ) u_collect (
    .clk        (wb_clk_i),
    .rst        (wb_rst_i),
    .start_i    (col_start),
    .active_i   (col_active),
    .en_mask_i  (en_mask),
    .is_read_i  (!we_q),
    .resp_i     (snoop_response_i),
    .dat_i      (snooped_dat_i),
    .all_seen_o (all_seen),
    .any_hit_o  (any_hit),
    .hit_dat_o  (hit_dat)
  );

  always_comb begin
    state_d      = state_q;
    adr_d        = adr_q;
    we_d         = we_q;
    core_d       = core_q;
    fwd_dat_d    = fwd_dat_q;
    col_start    = 1'b0;
    col_active   = 1'b0;
    req_ready_o  = 1'b0;
    snoop_type_o = SNOOP_TYPE_IDLE;
    snoop_en_o   = '0;
    mem_req_o    = 1'b0;
    fwd_valid_o  = 1'b0;
    done_o       = 1'b0;
`ifdef WB_SNOOP_TIMEOUT_EN
    timeout_o    = 1'b0;
    cnt_d        = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          adr_d     = req_adr_i;
          we_d      = req_we_i;
          core_d    = req_core_i;
          col_start = 1'b1;
          state_d   = ST_SNOOP;
`ifdef WB_SNOOP_TIMEOUT_EN
          cnt_d     = '0;
`endif
        end
      end
      ST_SNOOP: begin
        col_active   = 1'b1;
        snoop_type_o = we_q ? SNOOP_TYPE_WRITE : SNOOP_TYPE_READ;
        snoop_en_o   = en_mask;
`ifdef WB_SNOOP_TIMEOUT_EN
        cnt_d        = cnt_q + 1'b1;
`endif
        // Resolution waits for every snooped core, so a later lower-index
        // hit still wins over an earlier higher-index one.
        if (all_seen) begin
          if (!we_q && any_hit) begin
            fwd_dat_d = hit_dat;
            state_d   = ST_FORWARD;
          end else begin
            state_d = ST_MEM;
          end
        end
`ifdef WB_SNOOP_TIMEOUT_EN
        else if (timeout_hit) begin
          if (!we_q && any_hit) begin
            fwd_dat_d = hit_dat;
            state_d   = ST_FORWARD;
          end else begin
            timeout_o = 1'b1;
            state_d   = ST_MEM;
          end
        end
`endif
      end
      ST_FORWARD: begin
        fwd_valid_o = 1'b1;
        done_o      = 1'b1;
        state_d     = ST_IDLE;
      end
      ST_MEM: begin
        mem_req_o = 1'b1;
        if (mem_done_i) begin
          done_o  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      we_q      <= 1'b0;
      core_q    <= '0;
      fwd_dat_q <= '0;
`ifdef WB_SNOOP_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      we_q      <= we_d;
      core_q    <= core_d;
      fwd_dat_q <= fwd_dat_d;
`ifdef WB_SNOOP_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  assign snoop_adr_o = adr_q;
  assign fwd_dat_o   = fwd_dat_q;

endmodule

// File: tb/tb_wb_snoop_ctrl.sv
// tb_wb_snoop_ctrl
// Directed bench for wb_snoop_ctrl with three instances (1, 2 and 4 cores).
// Inputs are driven 1 time unit after the rising edge; outputs are checked on
// the falling edge of the same cycle. Cycle 0 is the cycle in which the
// request is presented and accepted.
module tb_wb_snoop_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  // num_cores = 2
  logic        r2_valid, r2_we, r2_mdone;
  logic [0:0]  r2_core;
  logic [31:0] r2_adr;
  logic [3:0]  r2_resp;
  logic [63:0] r2_dat;
  logic        o2_ready, o2_mreq, o2_fv, o2_done, o2_to;
  logic [31:0] o2_sadr, o2_fd;
  logic [1:0]  o2_stype, o2_sen;

  // num_cores = 4
  logic         r4_valid, r4_we, r4_mdone;
  logic [1:0]   r4_core;
  logic [31:0]  r4_adr;
  logic [7:0]   r4_resp;
  logic [127:0] r4_dat;
  logic         o4_ready, o4_mreq, o4_fv, o4_done, o4_to;
  logic [31:0]  o4_sadr, o4_fd;
  logic [1:0]   o4_stype;
  logic [3:0]   o4_sen;

  // num_cores = 1
  logic        r1_valid, r1_we, r1_mdone;
  logic [0:0]  r1_core;
  logic [31:0] r1_adr;
  logic [1:0]  r1_resp;
  logic [31:0] r1_dat;
  logic        o1_ready, o1_mreq, o1_fv, o1_done, o1_to;
  logic [31:0] o1_sadr, o1_fd;
  logic [1:0]  o1_stype;
  logic [0:0]  o1_sen;

  wb_snoop_ctrl #(.dw(32), .aw(32), .num_cores(2), .snoop_timeout(16)) dut2 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(r2_valid), .req_ready_o(o2_ready), .req_core_i(r2_core),
    .req_adr_i(r2_adr), .req_we_i(r2_we),
    .snoop_adr_o(o2_sadr), .snoop_type_o(o2_stype), .snoop_en_o(o2_sen),
    .snoop_response_i(r2_resp), .snooped_dat_i(r2_dat),
    .mem_req_o(o2_mreq), .mem_done_i(r2_mdone),
    .fwd_valid_o(o2_fv), .fwd_dat_o(o2_fd), .done_o(o2_done), .timeout_o(o2_to)
  );

  wb_snoop_ctrl #(.dw(32), .aw(32), .num_cores(4), .snoop_timeout(16)) dut4 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(r4_valid), .req_ready_o(o4_ready), .req_core_i(r4_core),
    .req_adr_i(r4_adr), .req_we_i(r4_we),
    .snoop_adr_o(o4_sadr), .snoop_type_o(o4_stype), .snoop_en_o(o4_sen),
    .snoop_response_i(r4_resp), .snooped_dat_i(r4_dat),
    .mem_req_o(o4_mreq), .mem_done_i(r4_mdone),
    .fwd_valid_o(o4_fv), .fwd_dat_o(o4_fd), .done_o(o4_done), .timeout_o(o4_to)
  );

  wb_snoop_ctrl #(.dw(32), .aw(32), .num_cores(1), .snoop_timeout(16)) dut1 (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .req_valid_i(r1_valid), .req_ready_o(o1_ready), .req_core_i(r1_core),
    .req_adr_i(r1_adr), .req_we_i(r1_we),
    .snoop_adr_o(o1_sadr), .snoop_type_o(o1_stype), .snoop_en_o(o1_sen),
    .snoop_response_i(r1_resp), .snooped_dat_i(r1_dat),
    .mem_req_o(o1_mreq), .mem_done_i(r1_mdone),
    .fwd_valid_o(o1_fv), .fwd_dat_o(o1_fd), .done_o(o1_done), .timeout_o(o1_to)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [63:0] got,
                             input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Moves to the start of the next cycle, where inputs may be changed.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Waits for the middle of the current cycle, where outputs are checked.
  task automatic settle();
    @(negedge clk);
  endtask

  // Safety net so the run always ends.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    r2_valid = 0; r2_we = 0; r2_mdone = 0; r2_core = 0; r2_adr = 0; r2_resp = 0; r2_dat = 0;
    r4_valid = 0; r4_we = 0; r4_mdone = 0; r4_core = 0; r4_adr = 0; r4_resp = 0; r4_dat = 0;
    r1_valid = 0; r1_we = 0; r1_mdone = 0; r1_core = 0; r1_adr = 0; r1_resp = 0; r1_dat = 0;

    // Reset state.
    applyStimulus();
    applyStimulus();
    settle();
    checkOutput("rst_ready", o2_ready, 1);
    checkOutput("rst_mreq", o2_mreq, 0);
    checkOutput("rst_stype", o2_stype, 0);
    checkOutput("rst_sen", o2_sen, 0);
    checkOutput("rst_sadr", o2_sadr, 0);
    checkOutput("rst_fd", o2_fd, 0);
    checkOutput("rst_done", o2_done, 0);
    checkOutput("rst_fv", o2_fv, 0);
    checkOutput("rst_to", o2_to, 0);
    applyStimulus();
    rst = 1'b0;

    // Read hit: core 0 reads 0x1000, core 1 hits with 0xDEADBEEF.
    applyStimulus();
    r2_valid = 1; r2_core = 0; r2_adr = 32'h1000; r2_we = 0;
    settle();
    checkOutput("rd_accept_ready", o2_ready, 1);
    applyStimulus();
    r2_valid = 0;
    r2_resp = 4'b10_00;
    r2_dat = {32'hDEADBEEF, 32'h0000_0000};
    settle();
    checkOutput("rd_stype", o2_stype, 2'b01);
    checkOutput("rd_sen", o2_sen, 2'b10);
    checkOutput("rd_sadr", o2_sadr, 32'h1000);
    checkOutput("rd_ready_snoop", o2_ready, 0);
    checkOutput("rd_mreq_c1", o2_mreq, 0);
    applyStimulus();
    r2_resp = 0; r2_dat = 0;
    settle();
    checkOutput("rd_fv", o2_fv, 1);
    checkOutput("rd_fd", o2_fd, 32'hDEADBEEF);
    checkOutput("rd_done", o2_done, 1);
    checkOutput("rd_mreq_c2", o2_mreq, 0);
    checkOutput("rd_stype_fwd", o2_stype, 0);
    applyStimulus();
    settle();
    checkOutput("rd_fv_c3", o2_fv, 0);
    checkOutput("rd_done_c3", o2_done, 0);
    checkOutput("rd_ready_c3", o2_ready, 1);
    checkOutput("rd_fd_hold", o2_fd, 32'hDEADBEEF);

    // Write: core 1 writes 0x2000, core 0 pending 3 cycles then 11.
    applyStimulus();
    r2_valid = 1; r2_core = 1; r2_adr = 32'h2000; r2_we = 1;
    settle();
    for (int n = 1; n <= 3; n++) begin
      applyStimulus();
      r2_valid = 0;
      settle();
      checkOutput("wr_stype_wait", o2_stype, 2'b10);
      checkOutput("wr_sen", o2_sen, 2'b01);
      checkOutput("wr_mreq_wait", o2_mreq, 0);
    end
    applyStimulus();
    r2_resp = 4'b00_11;
    settle();
    checkOutput("wr_stype_c4", o2_stype, 2'b10);
    checkOutput("wr_mreq_c4", o2_mreq, 0);
    applyStimulus();
    r2_resp = 0;
    settle();
    checkOutput("wr_mreq_c5", o2_mreq, 1);
    checkOutput("wr_done_c5", o2_done, 0);
    checkOutput("wr_stype_mem", o2_stype, 0);
    applyStimulus();
    settle();
    checkOutput("wr_mreq_c6", o2_mreq, 1);
    applyStimulus();
    r2_mdone = 1;
    settle();
    checkOutput("wr_done_c7", o2_done, 1);
    checkOutput("wr_mreq_c7", o2_mreq, 1);
    checkOutput("wr_fv_c7", o2_fv, 0);
    applyStimulus();
    settle();
    checkOutput("wr_idle_mdone_ignored", o2_done, 0);
    checkOutput("wr_mreq_c8", o2_mreq, 0);
    checkOutput("wr_ready_c8", o2_ready, 1);
    applyStimulus();
    r2_mdone = 0;

    // Read where the other core answers 11: treated as a miss.
    r2_valid = 1; r2_core = 1; r2_adr = 32'h2400; r2_we = 0;
    settle();
    applyStimulus();
    r2_valid = 0;
    r2_resp = 4'b00_11;
    settle();
    checkOutput("rdack_stype", o2_stype, 2'b01);
    applyStimulus();
    r2_resp = 0;
    r2_mdone = 1;
    settle();
    checkOutput("rdack_mreq", o2_mreq, 1);
    checkOutput("rdack_fv", o2_fv, 0);
    checkOutput("rdack_done", o2_done, 1);
    applyStimulus();
    r2_mdone = 0;
    settle();
    checkOutput("rdack_ready", o2_ready, 1);
    checkOutput("rdack_fd_hold", o2_fd, 32'hDEADBEEF);

    // Four cores: core 2 reads, cores 0 and 3 hit, core 1 misses,
    // core 2 drives a hit on itself that must be ignored.
    applyStimulus();
    r4_valid = 1; r4_core = 2; r4_adr = 32'h3000; r4_we = 0;
    settle();
    applyStimulus();
    r4_valid = 0;
    r4_resp = 8'b10_10_01_10;
    r4_dat = {32'h0000_000B, 32'h0000_000C, 32'h0000_000D, 32'h0000_000A};
    settle();
    checkOutput("c4_sen", o4_sen, 4'b1011);
    checkOutput("c4_stype", o4_stype, 2'b01);
    applyStimulus();
    r4_resp = 0; r4_dat = 0;
    settle();
    checkOutput("c4_fv", o4_fv, 1);
    checkOutput("c4_fd_lowest", o4_fd, 32'h0000_000A);
    checkOutput("c4_done", o4_done, 1);
    checkOutput("c4_mreq", o4_mreq, 0);

    // Single core: nothing to snoop, straight to memory.
    applyStimulus();
    r1_valid = 1; r1_core = 0; r1_adr = 32'h40; r1_we = 0;
    settle();
    applyStimulus();
    r1_valid = 0;
    settle();
    checkOutput("c1_sen", o1_sen, 0);
    checkOutput("c1_stype", o1_stype, 2'b01);
    checkOutput("c1_mreq_c1", o1_mreq, 0);
    applyStimulus();
    r1_mdone = 1;
    settle();
    checkOutput("c1_mreq_c2", o1_mreq, 1);
    checkOutput("c1_done", o1_done, 1);
    applyStimulus();
    r1_mdone = 0;
    settle();
    checkOutput("c1_ready", o1_ready, 1);

    // Reset during MEM drops the transaction; new request accepted right away.
    applyStimulus();
    r2_valid = 1; r2_core = 0; r2_adr = 32'h5000; r2_we = 0;
    settle();
    applyStimulus();
    r2_valid = 0;
    r2_resp = 4'b01_00;
    settle();
    applyStimulus();
    r2_resp = 0;
    settle();
    checkOutput("rstmem_mreq_c2", o2_mreq, 1);
    applyStimulus();
    rst = 1;
    settle();
    checkOutput("rstmem_done_c3", o2_done, 0);
    applyStimulus();
    rst = 0;
    r2_valid = 1; r2_core = 1; r2_adr = 32'h6000; r2_we = 1;
    settle();
    checkOutput("rstmem_mreq_c4", o2_mreq, 0);
    checkOutput("rstmem_done_c4", o2_done, 0);
    checkOutput("rstmem_ready_c4", o2_ready, 1);
    applyStimulus();
    r2_valid = 0;
    r2_resp = 4'b00_01;
    settle();
    checkOutput("rstmem_new_stype", o2_stype, 2'b10);
    checkOutput("rstmem_new_sadr", o2_sadr, 32'h6000);
    checkOutput("rstmem_new_sen", o2_sen, 2'b01);
    applyStimulus();
    r2_resp = 0;
    r2_mdone = 1;
    settle();
    checkOutput("rstmem_new_done", o2_done, 1);
    applyStimulus();
    r2_mdone = 0;

    // Core 1 never answers a read from core 0.
    r2_valid = 1; r2_core = 0; r2_adr = 32'h7000; r2_we = 0;
    settle();
    for (int n = 1; n <= 15; n++) begin
      applyStimulus();
      r2_valid = 0;
      settle();
      checkOutput("to_quiet", o2_to, 0);
    end
`ifdef WB_SNOOP_TIMEOUT_EN
    applyStimulus();
    settle();
    checkOutput("to_pulse", o2_to, 1);
    checkOutput("to_stype_c16", o2_stype, 2'b01);
    applyStimulus();
    r2_mdone = 1;
    settle();
    checkOutput("to_pulse_off", o2_to, 0);
    checkOutput("to_mreq", o2_mreq, 1);
    checkOutput("to_done", o2_done, 1);
    applyStimulus();
    r2_mdone = 0;
    settle();
    checkOutput("to_ready", o2_ready, 1);
`else
    repeat (85) applyStimulus();
    settle();
    checkOutput("noto_stype", o2_stype, 2'b01);
    checkOutput("noto_ready", o2_ready, 0);
    checkOutput("noto_to", o2_to, 0);
    checkOutput("noto_mreq", o2_mreq, 0);
    applyStimulus();
    rst = 1;
    applyStimulus();
    rst = 0;
    settle();
    checkOutput("noto_ready_after_rst", o2_ready, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
